// File: rtl/riscv_pkg.sv
// Shared core definitions: canonical NOP encoding and fetch-stage state type.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ     = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall; a pending hold entry beats a fresh response.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  input  logic            stall,
  input  logic            holdValid,
  input  logic [31:0]     holdInstr,
  input  logic [XLEN-1:0] holdPc,
  input  logic            rspValid,
  input  logic [31:0]     rspInstr,
  input  logic [XLEN-1:0] rspPc,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (flush) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!stall) begin
      if (holdValid) begin
        InstrD   <= holdInstr;
        PCD      <= holdPc;
        PCPlus4D <= holdPc + XLEN'(4);
        ValidD   <= 1'b1;
      end else if (rspValid) begin
        InstrD   <= rspInstr;
        PCD      <= rspPc;
        PCPlus4D <= rspPc + XLEN'(4);
        ValidD   <= 1'b1;
      end else begin
        // Bubble: PCD/PCPlus4D keep their last value, ValidD marks them meaningless.
        InstrD <= NOP_INSTR;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request FSM, one-entry hold buffer,
// and the IF/ID register feeding decode.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            ImemReqF,
  output logic [XLEN-1:0] ImemAddrF,
  input  logic            ImemGntF,
  input  logic            ImemRvalidF,
  input  logic [31:0]     ImemRdataF,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  fetch_state_t    state;
  logic [XLEN-1:0] pcF;
  logic [XLEN-1:0] reqPc;
  logic            holdValid;
  logic [31:0]     holdInstr;
  logic [XLEN-1:0] holdPc;

  logic            transfer;
  logic            rspAvail;
  logic [XLEN-1:0] targetPc;
  logic [1:0]      unusedTgtLo;

  assign targetPc    = {PCTargetE[XLEN-1:2], 2'b00};
  assign unusedTgtLo = PCTargetE[1:0];

  // Request is combinational so a same-cycle redirect can withdraw it.
  assign ImemReqF  = (state == REQ) & ~holdValid & ~StallF & ~PCSrcE;
  assign ImemAddrF = pcF;
  assign transfer  = ImemReqF & ImemGntF;
  assign rspAvail  = (state == WAIT) & ImemRvalidF & ~PCSrcE;

  // PC, outstanding-request address and request FSM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= REQ;
      pcF   <= RESET_PC;
      reqPc <= '0;
    end else begin
      if (PCSrcE) begin
        pcF <= targetPc;
      end else if (transfer) begin
        pcF   <= pcF + XLEN'(4);
        reqPc <= pcF;
      end
      case (state)
        REQ:     if (transfer) state <= WAIT;
        WAIT: begin
          if (ImemRvalidF)  state <= REQ;
          else if (PCSrcE)  state <= DISCARD;
        end
        DISCARD: if (ImemRvalidF) state <= REQ;
        default: state <= REQ;
      endcase
    end
  end

  // Parks a response that decode cannot take yet; blocks new requests while full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      holdValid <= 1'b0;
      holdInstr <= '0;
      holdPc    <= '0;
    end else if (PCSrcE) begin
      holdValid <= 1'b0;
    end else if (holdValid && !FlushD && !StallD) begin
      holdValid <= 1'b0;
    end else if (rspAvail && StallD && !FlushD) begin
      holdValid <= 1'b1;
      holdInstr <= ImemRdataF;
      holdPc    <= reqPc;
    end
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (FlushD),
    .stall     (StallD),
    .holdValid (holdValid),
    .holdInstr (holdInstr),
    .holdPc    (holdPc),
    .rspValid  (rspAvail),
    .rspInstr  (ImemRdataF),
    .rspPc     (reqPc),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

endmodule
